// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the handshaked data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int LANES      = WORD_BYTES;

    function automatic int idx_width(input int words);
        return $clog2(words);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-lane storage: synchronous masked write, combinational word read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    parameter int IW        = idx_width(MEM_WORDS)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_idx,
    input  logic [LANES-1:0] wr_be,
    input  logic [31:0]      wr_data,
    input  logic [IW-1:0]    rd_idx,
    output logic [31:0]      rd_data
);

    logic [31:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/data_mem_responder.sv
// Valid/ready data-memory slave with WAIT_STATES cycles of latency per request.
// Build option DMEM_ERR_RESP_EN: flag misaligned/out-of-range requests via resp_err.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         IW        = idx_width(MEM_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t           state, state_nxt;
    logic [3:0]       cnt;
    logic             accept, enter_resp;

    logic             req_err;
    logic [IW-1:0]    req_idx;

    logic             wr_q, err_q;
    logic [IW-1:0]    idx_q;
    logic [LANES-1:0] be_q;
    logic [31:0]      wdata_q;

    logic             cur_write, cur_err;
    logic [IW-1:0]    cur_idx;
    logic [LANES-1:0] cur_be;
    logic [31:0]      cur_wdata;
    logic [31:0]      rd_data;

    assign req_idx = req_addr[IW+1:2];

`ifdef DMEM_ERR_RESP_EN
    assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:IW+2] != '0);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:IW+2], req_addr[1:0]};
    assign req_err          = 1'b0;
`endif

    assign accept     = (state == IDLE) && req_ready && req_valid;
    assign enter_resp = (state != RESP) && (state_nxt == RESP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (WAIT_STATES == 0) ? RESP : BUSY;
            BUSY:    if (cnt == 4'd1) state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        resp_valid = (state == RESP);
    end

    // With zero wait states RESP is entered on the acceptance edge, so the
    // live request feeds the array instead of the not-yet-loaded latches.
    always_comb begin
        if (state == IDLE) begin
            cur_write = req_write;
            cur_err   = req_err;
            cur_idx   = req_idx;
            cur_be    = req_be;
            cur_wdata = req_wdata;
        end else begin
            cur_write = wr_q;
            cur_err   = err_q;
            cur_idx   = idx_q;
            cur_be    = be_q;
            cur_wdata = wdata_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= 4'd0;
            req_ready  <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            req_ready <= (state_nxt == IDLE);
            if (accept)              cnt <= WAIT_INIT;
            else if (state == BUSY)  cnt <= cnt - 4'd1;
            if (enter_resp) begin
                resp_err   <= cur_err;
                resp_rdata <= (cur_write || cur_err) ? 32'd0 : rd_data;
            end else if ((state == RESP) && resp_ready) begin
                resp_err   <= 1'b0;
                resp_rdata <= 32'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= req_write;
            err_q   <= req_err;
            idx_q   <= req_idx;
            be_q    <= req_be;
            wdata_q <= req_wdata;
        end
    end

    dmem_array #(
        .MEM_WORDS (MEM_WORDS),
        .IW        (IW)
    ) u_array (
        .clk     (clk),
        .wr_en   (enter_resp && cur_write && !cur_err),
        .wr_idx  (cur_idx),
        .wr_be   (cur_be),
        .wr_data (cur_wdata),
        .rd_idx  (cur_idx),
        .rd_data (rd_data)
    );

    a_no_overlap: assert property (@(posedge clk) disable iff (!reset)
        !(req_ready && resp_valid));
    a_idle_quiet: assert property (@(posedge clk) disable iff (!reset)
        (state == IDLE) |-> !resp_valid);

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder (WAIT_STATES=2 main instance, WAIT_STATES=0 side instance).
module tb_data_mem_responder;

    localparam int MW = 256;
    localparam int WS = 2;
`ifdef DMEM_ERR_RESP_EN
    localparam bit ERRB = 1'b1;
`else
    localparam bit ERRB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        z_req_valid = 1'b0, z_req_write = 1'b0, z_resp_ready = 1'b0;
    logic [31:0] z_req_addr = '0, z_req_wdata = '0;
    logic [3:0]  z_req_be = '0;
    logic        z_req_ready, z_resp_valid, z_resp_err;
    logic [31:0] z_resp_rdata;

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] model_mem [MW];

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_er;
    } vec_t;
    vec_t vecs [11];

    always #5 clk = ~clk;

    data_mem_responder #(.MEM_WORDS(MW), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    data_mem_responder #(.MEM_WORDS(MW), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
        .req_addr(z_req_addr), .req_be(z_req_be), .req_wdata(z_req_wdata),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference: word memory addressed by byte address, lane-wise stores.
    function automatic void mdl(input logic w, input logic [31:0] a, input logic [3:0] be,
                                input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int idx;
        idx = int'((a / 4) % MW);
        er  = ERRB && ((a % 4 != 0) || (a >= 32'(MW * 4)));
        rd  = '0;
        if (!er) begin
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) model_mem[idx][8*i +: 8] = wd[8*i +: 8];
            end else begin
                rd = model_mem[idx];
            end
        end
    endfunction

    // Drive one request, report data, error and edges from acceptance to resp_valid.
    task automatic txn(input logic w, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input int hold,
                       output logic [31:0] rd, output logic er, output int lat);
        int g;
        req_valid = 1'b1; req_write = w; req_addr = a; req_be = be; req_wdata = wd;
        g = 0;
        while (req_ready !== 1'b1 && g < 50) begin @(posedge clk); #1; g++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom); req_addr = $urandom; req_be = 4'($urandom); req_wdata = $urandom;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
        repeat (hold) begin @(posedge clk); #1; end
        rd = resp_rdata; er = resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    // Counting the acceptance edge itself, the response is up WS+1 edges in (lat == WS).
    task automatic run_chk(input string nm, input logic w, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] wd, input int hold,
                           input logic [31:0] exp_rd, input logic exp_er);
        logic [31:0] rd;
        logic        er;
        int          lat;
        txn(w, a, be, wd, hold, rd, er, lat);
        chk({nm, " rdata"}, rd, exp_rd);
        chk({nm, " err"}, 32'(er), 32'(exp_er));
        chk({nm, " latency"}, 32'(lat), 32'(WS));
        chk({nm, " post-handshake"}, {29'd0, resp_valid, req_ready, resp_err}, 32'b010);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, pre;
        logic        er;
        int          g, idx;
        logic [31:0] a;

        vecs[0]  = '{1'b1, 32'h10,  4'hF, 32'hDEADBEEF, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 32'h10,  4'h0, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h20,  4'hF, 32'h11223344, 32'h0, 1'b0};
        vecs[3]  = '{1'b1, 32'h20,  4'h5, 32'hAABBCCDD, 32'h0, 1'b0};
        vecs[4]  = '{1'b0, 32'h20,  4'h0, 32'h0,        32'h11BB33DD, 1'b0};
        vecs[5]  = '{1'b1, 32'h00,  4'hF, 32'hCAFEF00D, 32'h0, 1'b0};
        vecs[6]  = '{1'b0, 32'h13,  4'h0, 32'h0,        ERRB ? 32'h0 : 32'hDEADBEEF, ERRB};
        vecs[7]  = '{1'b1, 32'h400, 4'hF, 32'h12345678, 32'h0, ERRB};
        vecs[8]  = '{1'b0, 32'h00,  4'h0, 32'h0,        ERRB ? 32'hCAFEF00D : 32'h12345678, 1'b0};
        vecs[9]  = '{1'b1, 32'h20,  4'h0, 32'hFFFFFFFF, 32'h0, 1'b0};
        vecs[10] = '{1'b0, 32'h20,  4'h0, 32'h0,        32'h11BB33DD, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {req_ready, resp_valid, resp_err}, 32'b000);
        chk("reset rdata", resp_rdata, 32'h0);
        reset = 1'b1;
        #1;
        chk("ready before first edge", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("ready after first edge", {req_ready, resp_valid}, 32'b10);

        for (int i = 0; i < 11; i++)
            run_chk($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].be,
                    vecs[i].wd, 0, vecs[i].exp_rd, vecs[i].exp_er);

        // Backpressure: a second request waits behind a stalled response.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_be = 4'h0;
        g = 0;
        while (req_ready !== 1'b1 && g < 50) begin @(posedge clk); #1; g++; end
        @(posedge clk); #1;
        req_addr = 32'h20;
        g = 0;
        while (resp_valid !== 1'b1 && g < 50) begin @(posedge clk); #1; g++; end
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d valid/ready", c), {resp_valid, req_ready}, 32'b10);
            chk($sformatf("bp%0d rdata", c), resp_rdata, 32'hDEADBEEF);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("bp release", {resp_valid, req_ready}, 32'b01);
        chk("bp release rdata", resp_rdata, 32'h0);
        @(posedge clk); #1;
        chk("bp second accepted", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        g = 0;
        while (resp_valid !== 1'b1 && g < 50) begin @(posedge clk); #1; g++; end
        chk("bp second rdata", resp_rdata, 32'h11BB33DD);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;

        // Randomized traffic: preload words 0..63, then mixed requests.
        for (int i = 0; i < 64; i++) begin
            a = 32'(i * 4);
            mdl(1'b1, a, 4'hF, $urandom, rd, er);
            run_chk($sformatf("pre%0d", i), 1'b1, a, 4'hF, model_mem[i], 0, rd, er);
        end
        for (int i = 0; i < 150; i++) begin
            logic        w;
            logic [3:0]  be;
            logic [31:0] wd, hi, lo;
            idx = int'($urandom_range(0, 63));
            lo  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0;
            hi  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 15)) : 32'd0;
            a   = (hi << 10) | 32'(idx * 4) | lo;
            w   = 1'($urandom);
            be  = 4'($urandom);
            wd  = $urandom;
            mdl(w, a, be, wd, rd, er);
            run_chk($sformatf("rnd%0d", i), w, a, be, wd, int'($urandom_range(0, 3)), rd, er);
        end

        // Reset during BUSY drops a store to word 12.
        pre = model_mem[12];
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_be = 4'hF; req_wdata = ~pre;
        g = 0;
        while (req_ready !== 1'b1 && g < 50) begin @(posedge clk); #1; g++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("mid-reset outputs", {resp_valid, req_ready}, 32'b00);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post-reset ready", 32'(req_ready), 32'd1);
        run_chk("post-reset load", 1'b0, 32'h30, 4'h0, 32'h0, 0, pre, 1'b0);

        // Zero-wait-state instance: response is up right after the acceptance edge.
        chk("ws0 idle ready", 32'(z_req_ready), 32'd1);
        z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 32'h8;
        z_req_be = 4'hF; z_req_wdata = 32'h55AA55AA;
        @(posedge clk); #1;
        z_req_valid = 1'b0; z_req_wdata = 32'h0;
        chk("ws0 store resp", {z_resp_valid, z_req_ready, z_resp_err}, 32'b100);
        z_resp_ready = 1'b1;
        @(posedge clk); #1;
        z_resp_ready = 1'b0;
        chk("ws0 store done", {z_resp_valid, z_req_ready}, 32'b01);
        z_req_valid = 1'b1; z_req_write = 1'b0; z_req_addr = 32'h8;
        @(posedge clk); #1;
        z_req_valid = 1'b0;
        chk("ws0 load valid", 32'(z_resp_valid), 32'd1);
        chk("ws0 load rdata", z_resp_rdata, 32'h55AA55AA);
        z_resp_ready = 1'b1;
        @(posedge clk); #1;
        z_resp_ready = 1'b0;
        chk("ws0 load done", {z_resp_valid, z_resp_rdata[0]}, 32'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
